mp_control_fsm: RTL and testbench

//   Multicycle control unit sitting directly upstream of the 8-bit ALU. Owns PC and

---
 rtl/mp_control_fsm.sv | 189 ++++++++++++++++++
 tb/tb_mp_control_fsm.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_control_fsm.sv
// ---------------------------------------------------------------------------
// mp_control_fsm
//   Multicycle control unit for the 8-bit datapath. Owns the PC and the
//   instruction register, fetches 16-bit instructions and sequences them
//   through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). One instruction in flight.
//
//   Instruction: [15:13] opcode (= alufn), [12:10] rs, [9:7] rt, [6:4] rd,
//                [6:0] imm7.
//   Opcodes:     000 add, 001 sub, 010 and, 011 or, 100 addi, 101 lw,
//                110 sw, 111 beq.
//
//   Parameters
//     PC_W    PC / instruction-address width (word addressed)
//     RST_PC  PC value loaded on reset
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     imem_req/addr       fetch request (combinational, high in FETCH), address = pc
//     imem_rdata/ack      instruction word and fetch completion
//     alufn, alu_src_imm  ALU function and immediate-operand select
//     imm_out             sign-extended imm7
//     rs_sel, rt_sel      register-file read addresses
//     alubeq              ALU equality result, sampled at the end of EXEC for beq
//     dmem_re/we/ack      data-memory strobes (held until ack) and completion
//     rf_we, rf_waddr     register-file write pulse and address
//     wb_sel_mem          write-back source: 1 memory (lw), 0 ALU
//     pc                  current PC
//     retire_cnt          retired-instruction count (MP_RETIRE_CNT_EN only)
//
//   Build option
//     MP_RETIRE_CNT_EN    adds the retire_cnt port and its 16-bit counter.
// ---------------------------------------------------------------------------
module mp_control_fsm #(
    parameter int unsigned     PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [2:0]      alufn,
    output logic            alu_src_imm,
    output logic [7:0]      imm_out,
    output logic [2:0]      rs_sel,
    output logic [2:0]      rt_sel,
    input  logic            alubeq,
    output logic            dmem_re,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            rf_we,
    output logic [2:0]      rf_waddr,
    output logic            wb_sel_mem,
`ifdef MP_RETIRE_CNT_EN
    output logic [15:0]     retire_cnt,
`endif
    output logic [PC_W-1:0] pc
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_ADDI = 3'b100,
        OP_LW   = 3'b101,
        OP_SW   = 3'b110,
        OP_BEQ  = 3'b111
    } opcode_t;

    state_t          state;
    logic [15:0]     ir;
    opcode_t         op;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_ofs;

    assign op     = opcode_t'(ir[15:13]);
    assign pc_inc = pc + PC_W'(1);
    // Sized cast of a signed operand sign-extends imm7 to the PC width.
    assign br_ofs = PC_W'(signed'(ir[6:0]));

    // Decode outputs are pure functions of IR, which only changes on fetch.
    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign alufn       = ir[15:13];
    assign rs_sel      = ir[12:10];
    assign rt_sel      = ir[9:7];
    assign imm_out     = 8'(signed'(ir[6:0]));
    assign alu_src_imm = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    // Opcodes with bit 15 set (addi/lw) write rt; R-type writes rd.
    assign rf_waddr    = ir[15] ? ir[9:7] : ir[6:4];
    assign wb_sel_mem  = (op == OP_LW);

    // Strobes are registered: they are set on entry to MEM/WB and cleared on
    // exit, so they can never be high in FETCH and never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            pc      <= RST_PC;
            ir      <= '0;
            rf_we   <= 1'b0;
            dmem_re <= 1'b0;
            dmem_we <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_BEQ: begin
                            pc    <= alubeq ? (pc_inc + br_ofs) : pc_inc;
                            state <= S_FETCH;
                        end
                        OP_LW: begin
                            dmem_re <= 1'b1;
                            state   <= S_MEM;
                        end
                        OP_SW: begin
                            dmem_we <= 1'b1;
                            state   <= S_MEM;
                        end
                        default: begin
                            rf_we <= 1'b1;
                            state <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_re <= 1'b0;
                        dmem_we <= 1'b0;
                        if (op == OP_LW) begin
                            rf_we <= 1'b1;
                            state <= S_WB;
                        end else begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    rf_we <= 1'b0;
                    pc    <= pc_inc;
                    state <= S_FETCH;
                end
                default: begin
                    rf_we   <= 1'b0;
                    dmem_re <= 1'b0;
                    dmem_we <= 1'b0;
                    state   <= S_FETCH;
                end
            endcase
        end
    end

`ifdef MP_RETIRE_CNT_EN
    logic retire;

    // Retirement points: WB exit, sw completing MEM, beq leaving EXEC.
    assign retire = (state == S_WB) ||
                    (state == S_MEM  && dmem_ack && op == OP_SW) ||
                    (state == S_EXEC && op == OP_BEQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mp_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mp_control_fsm
//   Self-checking bench for mp_control_fsm. Each instruction is driven through
//   the fetch/memory handshakes and its observed behaviour is compared with an
//   instruction-level model (next pc, cycle count, strobe counts, decode).
//   Define MP_RETIRE_CNT_EN to also exercise the retire counter.
// ---------------------------------------------------------------------------
module tb_mp_control_fsm;

    localparam int unsigned PC_W   = 8;
    localparam logic [7:0]  RST_PC = 8'h00;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic [2:0]  alufn;
    logic        alu_src_imm;
    logic [7:0]  imm_out;
    logic [2:0]  rs_sel;
    logic [2:0]  rt_sel;
    logic        alubeq;
    logic        dmem_re;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic        wb_sel_mem;
    logic [7:0]  pc;
`ifdef MP_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pc_exp   = 0;
    int ret_exp  = 0;

    mp_control_fsm #(.PC_W(PC_W), .RST_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .alufn       (alufn),
        .alu_src_imm (alu_src_imm),
        .imm_out     (imm_out),
        .rs_sel      (rs_sel),
        .rt_sel      (rt_sel),
        .alubeq      (alubeq),
        .dmem_re     (dmem_re),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .wb_sel_mem  (wb_sel_mem),
`ifdef MP_RETIRE_CNT_EN
        .retire_cnt  (retire_cnt),
`endif
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cycles;
        int         rfwe_n;
        int         rfwe_cyc;
        int         re_n;
        int         we_n;
        logic [2:0] alufn;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] waddr;
        logic       src_imm;
        logic       wbmem;
        logic [7:0] imm;
        logic [7:0] pc_after;
        bit         overlap;
        bit         addr_bad;
        bit         timeout;
    } obs_t;

    // Instruction-level reference: what one instruction must do end to end.
    function automatic obs_t model(input logic [15:0] instr, input int pc_in,
                                   input bit beq, input int iw, input int dw);
        obs_t e;
        int   op;
        int   imm;
        int   npc;
        e   = '{default: 0};
        op  = int'(instr[15:13]);
        imm = int'(instr[6:0]);
        if (imm >= 64) imm = imm - 128;
        e.alufn   = instr[15:13];
        e.rs      = instr[12:10];
        e.rt      = instr[9:7];
        e.imm     = 8'(imm);
        e.src_imm = (op >= 4 && op <= 6);
        npc       = pc_in + 1;
        if (op <= 4) begin
            e.cycles   = iw + 4;
            e.rfwe_n   = 1;
            e.rfwe_cyc = e.cycles;
            e.waddr    = (op == 4) ? instr[9:7] : instr[6:4];
        end else if (op == 5) begin
            e.cycles   = iw + 5 + dw;
            e.re_n     = dw + 1;
            e.rfwe_n   = 1;
            e.rfwe_cyc = e.cycles;
            e.waddr    = instr[9:7];
            e.wbmem    = 1'b1;
        end else if (op == 6) begin
            e.cycles = iw + 4 + dw;
            e.we_n   = dw + 1;
        end else begin
            e.cycles = iw + 3;
            if (beq) npc = pc_in + 1 + imm;
        end
        e.pc_after = 8'(((npc % 256) + 256) % 256);
        return e;
    endfunction

    // Drives one instruction starting at a negedge in FETCH and records what
    // the DUT did until it returns to FETCH. Acks outside their waiting state
    // are randomised since they must be ignored.
    task automatic exec_instr(input logic [15:0] instr, input bit beq,
                              input int iw, input int dw, output obs_t o);
        int         fcnt;
        int         mcnt;
        bit         started;
        logic [7:0] pc0;
        o          = '{default: 0};
        o.timeout  = 1'b1;
        fcnt       = 0;
        mcnt       = 0;
        started    = 1'b0;
        pc0        = pc;
        imem_rdata = instr;
        alubeq     = beq;
        for (int k = 1; k <= 200; k++) begin
            if (imem_req && (dmem_re || dmem_we || rf_we)) o.overlap = 1'b1;
            if (int'(rf_we) + int'(dmem_re) + int'(dmem_we) > 1) o.overlap = 1'b1;
            if (imem_req && started) begin
                o.cycles   = k - 1;
                o.pc_after = pc;
                o.timeout  = 1'b0;
                break;
            end
            if (imem_req) begin
                if (imem_addr !== pc0 || pc !== pc0) o.addr_bad = 1'b1;
                imem_ack = (fcnt >= iw);
                fcnt++;
            end else begin
                if (!started) begin
                    o.alufn   = alufn;
                    o.rs      = rs_sel;
                    o.rt      = rt_sel;
                    o.src_imm = alu_src_imm;
                    o.imm     = imm_out;
                end
                started  = 1'b1;
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (rf_we) begin
                o.rfwe_n++;
                o.rfwe_cyc = k;
                o.waddr    = rf_waddr;
                o.wbmem    = wb_sel_mem;
            end
            if (dmem_re) o.re_n++;
            if (dmem_we) o.we_n++;
            if (dmem_re || dmem_we) begin
                dmem_ack = (mcnt >= dw);
                mcnt++;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (!o.timeout) ret_exp++;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        alubeq     = 1'b0;
        imem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        pc_exp  = int'(RST_PC);
        ret_exp = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            $display("FAIL reset_fetch: imem_req=%b imem_addr=%0d required 1/%0d", imem_req, imem_addr, RST_PC);
            n_fail++;
        end
        n_checks++;
        if (pc !== RST_PC) begin
            $display("FAIL reset_pc: pc=%0d required %0d", pc, RST_PC);
            n_fail++;
        end
        n_checks++;
        if ({rf_we, dmem_re, dmem_we} !== 3'b000) begin
            $display("FAIL reset_strobes: {rf_we,re,we}=%b required 000", {rf_we, dmem_re, dmem_we});
            n_fail++;
        end
        n_checks++;
        if (alufn !== 3'd0 || imm_out !== 8'd0 || rf_waddr !== 3'd0) begin
            $display("FAIL reset_decode: alufn=%0d imm=%0d waddr=%0d required 0/0/0", alufn, imm_out, rf_waddr);
            n_fail++;
        end
    endtask

    task automatic test_first_fetch();
        obs_t o;
        exec_instr(16'h0000, 1'b0, 0, 0, o);
        n_checks++;
        if (o.addr_bad || o.timeout) begin
            $display("FAIL first_fetch_addr: addr_bad=%0d timeout=%0d required 0/0", o.addr_bad, o.timeout);
            n_fail++;
        end
        n_checks++;
        if (o.rfwe_n !== 1 || o.rfwe_cyc !== 4 || o.cycles !== 4) begin
            $display("FAIL first_fetch_timing: rf_we count=%0d cycle=%0d cpi=%0d required 1/4/4", o.rfwe_n, o.rfwe_cyc, o.cycles);
            n_fail++;
        end
        n_checks++;
        if (o.pc_after !== 8'd1) begin
            $display("FAIL first_fetch_pc: pc=%0d required 1", o.pc_after);
            n_fail++;
        end
        pc_exp = 1;
    endtask

    task automatic test_add();
        obs_t o;
        exec_instr(16'h0530, 1'b0, 2, 0, o);
        n_checks++;
        if (o.alufn !== 3'd0 || o.src_imm !== 1'b0 || o.rs !== 3'd1 || o.rt !== 3'd2) begin
            $display("FAIL add_decode: alufn=%0d src_imm=%0d rs=%0d rt=%0d required 0/0/1/2", o.alufn, o.src_imm, o.rs, o.rt);
            n_fail++;
        end
        n_checks++;
        if (o.waddr !== 3'd3 || o.wbmem !== 1'b0 || o.rfwe_n !== 1 || o.cycles !== 6) begin
            $display("FAIL add_wb: waddr=%0d wbmem=%0d rf_we count=%0d cycles=%0d required 3/0/1/6", o.waddr, o.wbmem, o.rfwe_n, o.cycles);
            n_fail++;
        end
        pc_exp = pc_exp + 1;
    endtask

    task automatic test_lw();
        obs_t o;
        exec_instr(16'hA105, 1'b0, 0, 3, o);
        n_checks++;
        if (o.re_n !== 4 || o.we_n !== 0) begin
            $display("FAIL lw_dmem_re: re cycles=%0d we cycles=%0d required 4/0", o.re_n, o.we_n);
            n_fail++;
        end
        n_checks++;
        if (o.rfwe_n !== 1 || o.wbmem !== 1'b1 || o.waddr !== 3'd2 || o.rfwe_cyc !== 8) begin
            $display("FAIL lw_wb: rf_we count=%0d wbmem=%0d waddr=%0d cyc=%0d required 1/1/2/8", o.rfwe_n, o.wbmem, o.waddr, o.rfwe_cyc);
            n_fail++;
        end
        n_checks++;
        if (o.src_imm !== 1'b1 || o.imm !== 8'd5 || o.overlap) begin
            $display("FAIL lw_decode: src_imm=%0d imm=%0d overlap=%0d required 1/5/0", o.src_imm, o.imm, o.overlap);
            n_fail++;
        end
        pc_exp = pc_exp + 1;
    endtask

    task automatic test_beq();
        obs_t       o;
        logic [7:0] want [5] = '{8'd10, 8'd9, 8'd10, 8'd11, 8'd11};
        logic [15:0] ins [5] = '{16'hE009, 16'hE07E, 16'hE000, 16'hE07E, 16'hE07F};
        bit          tk  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exec_instr(ins[i], tk[i], i % 2, 0, o);
            n_checks++;
            if (o.pc_after !== want[i] || o.cycles !== 3 + (i % 2)) begin
                $display("FAIL beq_%0d: pc=%0d cycles=%0d required %0d/%0d", i, o.pc_after, o.cycles, want[i], 3 + (i % 2));
                n_fail++;
            end
            n_checks++;
            if (o.rfwe_n !== 0 || o.re_n !== 0 || o.we_n !== 0) begin
                $display("FAIL beq_strobes_%0d: rf_we=%0d re=%0d we=%0d required 0/0/0", i, o.rfwe_n, o.re_n, o.we_n);
                n_fail++;
            end
        end
        pc_exp = 11;
    endtask

    task automatic test_wrap();
        obs_t o;
        do_reset();
        exec_instr(16'hE07E, 1'b1, 0, 0, o);
        n_checks++;
        if (o.pc_after !== 8'hFF) begin
            $display("FAIL wrap_back: pc=%0h required ff", o.pc_after);
            n_fail++;
        end
        exec_instr(16'h0530, 1'b0, 0, 0, o);
        n_checks++;
        if (o.pc_after !== 8'h00) begin
            $display("FAIL wrap_seq: pc=%0h required 00", o.pc_after);
            n_fail++;
        end
        pc_exp = 0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   bad;
        exec_instr(16'h0530, 1'b0, 0, 0, o);
        imem_rdata = 16'hC085;
        imem_ack   = 1'b0;
        bad        = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (imem_req !== 1'b1 || pc !== 8'd1) bad = 1'b1;
        end
        imem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bad || imem_req !== 1'b0) begin
            $display("FAIL withheld_fetch: held_bad=%0d imem_req_in_exec=%b required 0/0", bad, imem_req);
            n_fail++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pc !== RST_PC || imem_req !== 1'b1 || {rf_we, dmem_re, dmem_we} !== 3'b000) begin
            $display("FAIL reset_mid_abort: pc=%0d imem_req=%b strobes=%b required %0d/1/000", pc, imem_req, {rf_we, dmem_re, dmem_we}, RST_PC);
            n_fail++;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        dmem_ack = 1'b1;
        bad      = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (imem_req !== 1'b1 || {rf_we, dmem_re, dmem_we} !== 3'b000 || pc !== RST_PC) bad = 1'b1;
        end
        dmem_ack = 1'b0;
        n_checks++;
        if (bad) begin
            $display("FAIL reset_mid_quiet: activity after abort=%0d required 0", bad);
            n_fail++;
        end
        pc_exp  = int'(RST_PC);
        ret_exp = 0;
    endtask

    task automatic test_random();
        obs_t        o;
        obs_t        e;
        logic [15:0] ins;
        bit          tk;
        int          iw;
        int          dw;
        for (int i = 0; i < 40; i++) begin
            ins = 16'($urandom);
            tk  = 1'($urandom_range(0, 1));
            iw  = int'($urandom_range(0, 3));
            dw  = int'($urandom_range(0, 3));
            e   = model(ins, pc_exp, tk, iw, dw);
            exec_instr(ins, tk, iw, dw, o);
            n_checks++;
            if (o.pc_after !== e.pc_after) begin
                $display("FAIL rand_pc_%0d: ins=%h pc=%0d required %0d", i, ins, o.pc_after, e.pc_after);
                n_fail++;
            end
            n_checks++;
            if (o.cycles !== e.cycles) begin
                $display("FAIL rand_cycles_%0d: ins=%h cycles=%0d required %0d", i, ins, o.cycles, e.cycles);
                n_fail++;
            end
            n_checks++;
            if (o.rfwe_n !== e.rfwe_n || o.rfwe_cyc !== e.rfwe_cyc || o.re_n !== e.re_n || o.we_n !== e.we_n) begin
                $display("FAIL rand_strobes_%0d: ins=%h rfwe=%0d@%0d re=%0d we=%0d required %0d@%0d/%0d/%0d", i, ins,
                         o.rfwe_n, o.rfwe_cyc, o.re_n, o.we_n, e.rfwe_n, e.rfwe_cyc, e.re_n, e.we_n);
                n_fail++;
            end
            n_checks++;
            if ({o.alufn, o.rs, o.rt, o.src_imm, o.imm} !== {e.alufn, e.rs, e.rt, e.src_imm, e.imm}) begin
                $display("FAIL rand_decode_%0d: ins=%h got %h required %h", i, ins,
                         {o.alufn, o.rs, o.rt, o.src_imm, o.imm}, {e.alufn, e.rs, e.rt, e.src_imm, e.imm});
                n_fail++;
            end
            n_checks++;
            if (o.waddr !== e.waddr || o.wbmem !== e.wbmem) begin
                $display("FAIL rand_wb_%0d: ins=%h waddr=%0d wbmem=%0d required %0d/%0d", i, ins, o.waddr, o.wbmem, e.waddr, e.wbmem);
                n_fail++;
            end
            n_checks++;
            if (o.overlap || o.addr_bad || o.timeout) begin
                $display("FAIL rand_safety_%0d: overlap=%0d addr_bad=%0d timeout=%0d required 0/0/0", i, o.overlap, o.addr_bad, o.timeout);
                n_fail++;
            end
            pc_exp = int'(e.pc_after);
        end
    endtask

`ifdef MP_RETIRE_CNT_EN
    task automatic test_retire();
        obs_t o;
        n_checks++;
        if (retire_cnt !== 16'(ret_exp)) begin
            $display("FAIL retire_running: retire_cnt=%0d required %0d", retire_cnt, ret_exp);
            n_fail++;
        end
        do_reset();
        n_checks++;
        if (retire_cnt !== 16'd0) begin
            $display("FAIL retire_reset: retire_cnt=%0d required 0", retire_cnt);
            n_fail++;
        end
        exec_instr(16'h0530, 1'b0, 0, 0, o);
        exec_instr(16'hC085, 1'b0, 0, 1, o);
        exec_instr(16'hE07F, 1'b1, 0, 0, o);
        n_checks++;
        if (retire_cnt !== 16'd3) begin
            $display("FAIL retire_three: retire_cnt=%0d required 3", retire_cnt);
            n_fail++;
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_add();
        test_lw();
        test_beq();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef MP_RETIRE_CNT_EN
        test_retire();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
